// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and helpers for the sized LEGv8 data memory:
//               access-size and FSM-state encodings, size decode and
//               alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Access size as carried on req_size
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    // Request-handling FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Width of the wait-state down-counter (WAIT_STATES is at most 15)
    localparam int WS_CNT_W = 4;

    // Number of bytes touched by an access of the given size
    function automatic logic [3:0] size_bytes(input size_e size);
        logic [3:0] n;
        case (size)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // True when the low address bits are a multiple of the access size
    function automatic logic is_aligned(input logic [2:0] addr_lo, input size_e size);
        logic ok;
        case (size)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = (addr_lo[0] == 1'b0);
            SZ_W:    ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_byte_lane.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_lane
// Description : Combinational byte-lane steering. For loads, extracts the
//               addressed bytes from a memory word, right-aligns them and
//               zero- or sign-extends. For stores, shifts the right-aligned
//               store data into its lane and builds the byte-enable mask.
//               Little-endian lane numbering.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_lane
    import dmem_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int NBYTES = DATA_W / 8,
    localparam int LANE_W = $clog2(NBYTES)
) (
    input  logic [LANE_W-1:0] lane_off,
    input  size_e             size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] rd_word,
    output logic [DATA_W-1:0] ld_data,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [DATA_W-1:0] st_data,
    output logic [NBYTES-1:0] st_be
);

    localparam int IDX_W = $clog2(DATA_W);

    logic [DATA_W-1:0] rd_shifted;
    logic [IDX_W-1:0]  msb_idx;
    logic              fill_bit;
    int                nbits;
    int                nbytes_acc;
    int                off_i;

    // Load path: right-align the addressed bytes, then extend above the access width
    always_comb begin
        ld_data    = '0;
        rd_shifted = rd_word >> {lane_off, 3'b000};
        nbits      = 8 * int'(size_bytes(size));
        // A double access on a 32-bit memory is flagged as an error upstream;
        // clamping keeps the sign-bit index inside the word.
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        msb_idx  = IDX_W'(nbits - 1);
        fill_bit = sign_ext & rd_shifted[msb_idx];
        for (int i = 0; i < DATA_W; i++) begin
            ld_data[i] = (i < nbits) ? rd_shifted[i] : fill_bit;
        end
    end

    // Store path: move data into its lane and enable only the addressed bytes
    always_comb begin
        st_be      = '0;
        st_data    = st_wdata << {lane_off, 3'b000};
        nbytes_acc = int'(size_bytes(size));
        off_i      = int'(lane_off);
        for (int b = 0; b < NBYTES; b++) begin
            st_be[b] = (b >= off_i) && (b < off_i + nbytes_acc);
        end
    end

endmodule : dmem_byte_lane
`default_nettype wire

// File: rtl/sized_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : sized_data_memory
// Description : Byte-addressed LEGv8 data memory with a valid/ready request
//               port, WAIT_STATES extra cycles of latency and byte/half/
//               word/double accesses with optional sign extension.
//               Misaligned or illegal accesses return rsp_error and leave
//               memory untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module sized_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error
);

    localparam int NBYTES = DATA_W / 8;
    localparam int LANE_W = $clog2(NBYTES);
    localparam int WIDX_W = ADDR_W - LANE_W;
    localparam int DEPTH  = 2 ** WIDX_W;
    localparam logic [WS_CNT_W-1:0] WS_LOAD =
        (WAIT_STATES > 0) ? WS_CNT_W'(WAIT_STATES - 1) : '0;

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    // Power-up image: word k holds k
    function automatic mem_t init_mem();
        mem_t m;
        for (int k = 0; k < DEPTH; k++) begin
            m[k] = DATA_W'(k);
        end
        return m;
    endfunction

    mem_t mem_q = init_mem();

    state_e              state_q,     state_d;
    logic [WS_CNT_W-1:0] cnt_q,       cnt_d;
    logic                write_q,     write_d;
    size_e               size_q,      size_d;
    logic                signed_q,    signed_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic                ready_q,     ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_error_q, rsp_error_d;

    logic                commit;
    logic                use_live;
    logic                cur_write;
    size_e               cur_size;
    logic                cur_signed;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic                cur_err;
    logic [WIDX_W-1:0]   widx;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   ld_data;
    logic [DATA_W-1:0]   st_data;
    logic [NBYTES-1:0]   st_be;
    logic                mem_we;

    // Access being committed: with no wait states the commit edge is the
    // accept edge, so the live request is used before it is captured.
    always_comb begin
        use_live   = (state_q == IDLE);
        cur_write  = use_live ? req_write          : write_q;
        cur_size   = use_live ? size_e'(req_size)  : size_q;
        cur_signed = use_live ? req_signed         : signed_q;
        cur_addr   = use_live ? req_addr           : addr_q;
        cur_wdata  = use_live ? req_wdata          : wdata_q;
        cur_err    = !is_aligned(cur_addr[2:0], cur_size) ||
                     ((cur_size == SZ_D) && (DATA_W == 32));
        widx       = cur_addr[ADDR_W-1:LANE_W];
        rd_word    = mem_q[widx];
        mem_we     = commit && cur_write && !cur_err && !rst;
    end

    dmem_byte_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .lane_off (cur_addr[LANE_W-1:0]),
        .size     (cur_size),
        .sign_ext (cur_signed),
        .rd_word  (rd_word),
        .ld_data  (ld_data),
        .st_wdata (cur_wdata),
        .st_data  (st_data),
        .st_be    (st_be)
    );

    // Next-state logic: request capture, wait countdown and response formation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = size_e'(req_size);
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            rsp_error_d = cur_err;
            rsp_rdata_d = (cur_err || cur_write) ? '0 : ld_data;
        end
        rsp_valid_d = commit;
        ready_d     = (state_d == IDLE);
    end

    // Control and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            size_q      <= SZ_B;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    // Storage array: byte-masked write on the edge entering RESP, never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (st_be[b]) begin
                    mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule : sized_data_memory
`default_nettype wire

// File: tb/tb_sized_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_sized_data_memory
// Description : Directed self-checking bench. Three instances (64-bit,
//               8-bit address) with WAIT_STATES 2, 3 and 0 exercise sized
//               loads/stores, sign extension, misalignment, reset during a
//               pending store and held-valid throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sized_data_memory;

    localparam logic [1:0] SZB = 2'b00;
    localparam logic [1:0] SZH = 2'b01;
    localparam logic [1:0] SZW = 2'b10;
    localparam logic [1:0] SZD = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [1:0]  req_size   [3];
    logic        req_signed [3];
    logic [7:0]  req_addr   [3];
    logic [63:0] req_wdata  [3];
    logic        rsp_valid  [3];
    logic [63:0] rsp_rdata  [3];
    logic        rsp_error  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Instance 0: WAIT_STATES=2, instance 1: 3, instance 2: 0
    for (genvar i = 0; i < 3; i++) begin : g_dut
        sized_data_memory #(
            .DATA_W      (64),
            .ADDR_W      (8),
            .WAIT_STATES ((i == 0) ? 2 : ((i == 1) ? 3 : 0))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[i]),
            .req_ready  (req_ready[i]),
            .req_write  (req_write[i]),
            .req_size   (req_size[i]),
            .req_signed (req_signed[i]),
            .req_addr   (req_addr[i]),
            .req_wdata  (req_wdata[i]),
            .rsp_valid  (rsp_valid[i]),
            .rsp_rdata  (rsp_rdata[i]),
            .rsp_error  (rsp_error[i])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp_v);
        end
    endtask

    // One access on instance d; called and returning at a falling edge.
    // lat counts cycles from accept to the response cycle (1 = next cycle).
    task automatic access(input int d, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [7:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic er, output int lat);
        int guard;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("ready_before_req_i%0d_a%h", d, a), {63'd0, req_ready[d]}, 64'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_size[d]   = sz;
        req_signed[d] = sg;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata[d];
        er = rsp_error[d];
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          acc[$];
        logic [63:0] resp[$];
        logic        seen;

        for (int i = 0; i < 3; i++) begin
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_size[i]   = SZB;
            req_signed[i] = 1'b0;
            req_addr[i]   = '0;
            req_wdata[i]  = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        check("rst_ready",     {63'd0, req_ready[0]}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid[0]}, 64'd0);
        check("rst_rsp_rdata", rsp_rdata[0],          64'd0);
        check("rst_rsp_error", {63'd0, rsp_error[0]}, 64'd0);

        // Initial image: word k holds k, response 3 cycles after accept
        for (int k = 0; k < 32; k++) begin
            access(0, 1'b0, SZD, 1'b0, 8'(8 * k), 64'd0, rd, er, lat);
            check($sformatf("init_ld_k%0d_data", k), rd, 64'(k));
            check($sformatf("init_ld_k%0d_err", k), {63'd0, er}, 64'd0);
            check($sformatf("init_ld_k%0d_lat", k), 64'(lat), 64'd3);
        end

        // Byte store and byte loads with/without sign extension
        access(0, 1'b1, SZB, 1'b0, 8'h13, 64'h0000_0000_0000_00A5, rd, er, lat);
        check("st_b_err",   {63'd0, er}, 64'd0);
        check("st_b_rdata", rd,          64'd0);
        access(0, 1'b0, SZD, 1'b0, 8'h10, 64'd0, rd, er, lat);
        check("ld_d_0x10", rd, 64'h0000_0000_A500_0002);
        access(0, 1'b0, SZB, 1'b1, 8'h13, 64'd0, rd, er, lat);
        check("ld_b_signed", rd, 64'hFFFF_FFFF_FFFF_FFA5);
        access(0, 1'b0, SZB, 1'b0, 8'h13, 64'd0, rd, er, lat);
        check("ld_b_unsigned", rd, 64'h0000_0000_0000_00A5);

        // Half store, signed half load, word load over it
        access(0, 1'b1, SZH, 1'b0, 8'h0A, 64'h0000_0000_0000_8001, rd, er, lat);
        check("st_h_err", {63'd0, er}, 64'd0);
        access(0, 1'b0, SZH, 1'b1, 8'h0A, 64'd0, rd, er, lat);
        check("ld_h_signed", rd, 64'hFFFF_FFFF_FFFF_8001);
        access(0, 1'b0, SZW, 1'b0, 8'h08, 64'd0, rd, er, lat);
        check("ld_w_0x08", rd, 64'h0000_0000_8001_0001);
        @(negedge clk);
        check("rdata_held",      rsp_rdata[0],          64'h0000_0000_8001_0001);
        check("rsp_valid_pulse", {63'd0, rsp_valid[0]}, 64'd0);

        // Misaligned accesses
        access(0, 1'b0, SZW, 1'b0, 8'h06, 64'd0, rd, er, lat);
        check("mis_ld_w_err",   {63'd0, er}, 64'd1);
        check("mis_ld_w_rdata", rd,          64'd0);
        access(0, 1'b1, SZH, 1'b0, 8'h01, 64'h0000_0000_0000_FFFF, rd, er, lat);
        check("mis_st_h_err", {63'd0, er}, 64'd1);
        access(0, 1'b0, SZD, 1'b0, 8'h00, 64'd0, rd, er, lat);
        check("mis_st_h_nochange", rd, 64'd0);
        check("after_err_ok",      {63'd0, er}, 64'd0);

        // Reset one cycle after accepting a store discards it (WAIT_STATES=3)
        check("ws3_ready", {63'd0, req_ready[1]}, 64'd1);
        req_valid[1]  = 1'b1;
        req_write[1]  = 1'b1;
        req_size[1]   = SZD;
        req_signed[1] = 1'b0;
        req_addr[1]   = 8'h20;
        req_wdata[1]  = 64'h0000_0000_DEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = rsp_valid[1];
        check("ws3_ready_after_rst", {63'd0, req_ready[1]}, 64'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen = seen | rsp_valid[1];
        end
        check("ws3_no_rsp", {63'd0, seen}, 64'd0);
        access(1, 1'b0, SZD, 1'b0, 8'h20, 64'd0, rd, er, lat);
        check("ws3_store_discarded", rd, 64'd4);
        check("ws3_lat", 64'(lat), 64'd4);

        // Held req_valid: one accept per 4 cycles, address changed while busy
        req_valid[0]  = 1'b1;
        req_write[0]  = 1'b0;
        req_size[0]   = SZD;
        req_signed[0] = 1'b0;
        req_addr[0]   = 8'h18;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid[0]) resp.push_back(rsp_rdata[0]);
            if (req_ready[0]) acc.push_back(c);
            else if (acc.size() == 1) req_addr[0] = 8'h28;
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        lat = 0;
        while (rsp_valid[0] !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("hold_accepts", 64'(acc.size()), 64'd3);
        check("hold_period_1", (acc.size() > 1) ? 64'(acc[1] - acc[0]) : 64'hFFFF, 64'd4);
        check("hold_period_2", (acc.size() > 2) ? 64'(acc[2] - acc[1]) : 64'hFFFF, 64'd4);
        check("hold_rsps", 64'(resp.size()), 64'd2);
        check("hold_rsp_0", (resp.size() > 0) ? resp[0] : 64'hBAD, 64'd3);
        check("hold_rsp_1", (resp.size() > 1) ? resp[1] : 64'hBAD, 64'd5);
        check("hold_rsp_2", rsp_rdata[0], 64'd5);
        @(negedge clk);

        // Zero wait states: response one cycle after accept
        access(2, 1'b0, SZD, 1'b0, 8'h18, 64'd0, rd, er, lat);
        check("ws0_ld_data", rd, 64'd3);
        check("ws0_ld_lat",  64'(lat), 64'd1);
        access(2, 1'b1, SZW, 1'b0, 8'h04, 64'h0000_0000_1234_5678, rd, er, lat);
        check("ws0_st_w_err", {63'd0, er}, 64'd0);
        check("ws0_st_w_lat", 64'(lat), 64'd1);
        access(2, 1'b0, SZD, 1'b0, 8'h00, 64'd0, rd, er, lat);
        check("ws0_ld_d_0x00", rd, 64'h1234_5678_0000_0000);
        access(2, 1'b0, SZB, 1'b0, 8'h07, 64'd0, rd, er, lat);
        check("ws0_ld_b_0x07", rd, 64'h0000_0000_0000_0012);
        access(2, 1'b0, SZH, 1'b1, 8'h06, 64'd0, rd, er, lat);
        check("ws0_ld_h_signed_pos", rd, 64'h0000_0000_0000_1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sized_data_memory
`default_nettype wire
